audio_sram_ctrl: RTL

- Sits directly downstream and upstream of the I2S transceiver. Consumes its 16-bit captured samples and write pulses, and stores them sequentially in the external 16-bit asynchronous SRAM.
- Serves its read pulses during playback with samples fetched from SRAM, supporting fast (skip) and slow (repeat) playback.
- Clocked on the same negedge-BCLK domain as the I2S block; top-level FSM issues record/play/pause/stop commands.

---
 rtl/audio_sram_ctrl.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/audio_sram_ctrl.sv
// audio_sram_ctrl: records I2S capture samples into a 16-bit async SRAM and
// plays them back to the I2S transmitter with fast (skip) / slow (repeat) modes.
// Optional build macro AUDIO_SRAM_PLAY_LOOP_EN: when defined, playback wraps to
// address 0 at the end of the recording instead of returning to IDLE.
// o_addr_end carries one extra bit so a completely full memory (2**AW words)
// has a representable length.
module audio_sram_ctrl #(
  parameter int unsigned AW       = 20,
  parameter int unsigned ADDR_MAX = (2 ** AW) - 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cmd_rec,
  input  logic          i_cmd_play,
  input  logic          i_cmd_pause,
  input  logic          i_cmd_stop,
  input  logic          i_fast,
  input  logic [2:0]    i_speed,
  input  logic          i_wr_req,
  input  logic [15:0]   i_wr_data,
  input  logic          i_rd_req,
  output logic [15:0]   o_rd_data,
  output logic          o_rd_valid,
  output logic [AW-1:0] o_sram_addr,
  inout  wire  [15:0]   io_sram_dq,
  output logic          o_sram_we_n,
  output logic          o_sram_oe_n,
  output logic          o_sram_ce_n,
  output logic          o_sram_lb_n,
  output logic          o_sram_ub_n,
  output logic [1:0]    o_state,
  output logic [AW-1:0] o_addr_cur,
  output logic [AW:0]   o_addr_end,
  output logic          o_full,
  output logic          o_overrun
);

  localparam int unsigned EW = AW + 1;  // recording length width
  localparam int unsigned PW = AW + 4;  // pointer math width, room for +8 overshoot

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REC   = 2'd1,
    ST_PLAY  = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  // Kind of access occupying the two-cycle access window
  typedef enum logic [1:0] {
    K_WR  = 2'd0,
    K_RD  = 2'd1,
    K_SIL = 2'd2
  } kind_t;

  state_t        state_q;
  logic          resume_rec_q;
  logic [AW-1:0] addr_cur_q;
  logic [EW-1:0] addr_end_q;
  logic [2:0]    rep_q;
  logic          fast_q;
  logic [2:0]    speed_q;
  logic          full_q;
  logic          overrun_q;
  logic [15:0]   rd_data_q;
  logic          rd_valid_q;
  logic [AW-1:0] sram_addr_q;
  logic [15:0]   wdata_q;
  logic          we_n_q;
  logic          oe_n_q;
  logic          dq_oe_q;
  logic          s1_q;
  logic          s2_q;
  kind_t         kind1_q;
  kind_t         kind2_q;
  logic          abort_q;

  logic          busy_c;
  logic          wr_take_c;
  logic          rd_take_c;
  logic          ovr_c;
  logic          stop_c;
  logic          wr_fin_c;
  logic          rd_fin_c;
  logic          sil_fin_c;
  logic          wr_last_c;
  logic          mode_chg_c;
  logic [2:0]    rep_eff_c;
  logic [PW-1:0] adv_addr_d;
  logic [2:0]    adv_rep_d;
  logic          play_end_d;

  // Request arbitration against the access window and the current mode
  assign busy_c    = s1_q | s2_q;
  assign wr_take_c = i_wr_req && (state_q == ST_REC) && !busy_c;
  assign rd_take_c = i_rd_req && !busy_c && !(i_wr_req && (state_q == ST_REC));
  assign ovr_c     = busy_c && (i_rd_req || (i_wr_req && (state_q == ST_REC)));
  assign stop_c    = i_cmd_stop | abort_q;
  assign wr_fin_c  = s1_q && (kind1_q == K_WR)  && !stop_c;
  assign rd_fin_c  = s1_q && (kind1_q == K_RD)  && !stop_c;
  assign sil_fin_c = s1_q && (kind1_q == K_SIL) && !stop_c;
  assign wr_last_c = (sram_addr_q == AW'(ADDR_MAX));
  assign mode_chg_c = (i_fast != fast_q) || (i_speed != speed_q);
  assign rep_eff_c  = mode_chg_c ? 3'd0 : rep_q;

  // Next playback pointer and repeat count for the read finishing this cycle
  always_comb begin
    adv_addr_d = PW'(addr_cur_q);
    adv_rep_d  = 3'd0;
    if (i_fast) begin
      adv_addr_d = PW'(addr_cur_q) + PW'(i_speed) + PW'(1);
    end else if (rep_eff_c == i_speed) begin
      adv_addr_d = PW'(addr_cur_q) + PW'(1);
    end else begin
      adv_rep_d = rep_eff_c + 3'd1;
    end
    play_end_d = (adv_addr_d >= PW'(addr_end_q));
  end

  // Mode FSM, access sequencer and pointers; commands are applied last so they win
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q      <= ST_IDLE;
      resume_rec_q <= 1'b0;
      addr_cur_q   <= '0;
      addr_end_q   <= '0;
      rep_q        <= 3'd0;
      fast_q       <= 1'b0;
      speed_q      <= 3'd0;
      full_q       <= 1'b0;
      overrun_q    <= 1'b0;
      rd_data_q    <= 16'd0;
      rd_valid_q   <= 1'b0;
      sram_addr_q  <= '0;
      wdata_q      <= 16'd0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      dq_oe_q      <= 1'b0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      kind1_q      <= K_SIL;
      kind2_q      <= K_SIL;
      abort_q      <= 1'b0;
    end else begin
      s1_q       <= wr_take_c | rd_take_c;
      s2_q       <= s1_q;
      kind2_q    <= kind1_q;
      abort_q    <= (wr_take_c | rd_take_c | s1_q) & stop_c;
      rd_valid_q <= s2_q && (kind2_q != K_WR) && !stop_c;

      if (ovr_c) begin
        overrun_q <= 1'b1;
      end

      // Cycle 0: launch the access
      if (wr_take_c) begin
        kind1_q     <= K_WR;
        sram_addr_q <= addr_cur_q;
        wdata_q     <= i_wr_data;
        dq_oe_q     <= 1'b1;
        we_n_q      <= 1'b0;
      end else if (rd_take_c) begin
        if (state_q == ST_PLAY) begin
          kind1_q     <= K_RD;
          sram_addr_q <= addr_cur_q;
          oe_n_q      <= 1'b0;
        end else begin
          kind1_q <= K_SIL;
        end
      end

      // Cycle 1: close strobes; release the bus one cycle later
      if (s1_q) begin
        we_n_q <= 1'b1;
        oe_n_q <= 1'b1;
      end
      if (s2_q) begin
        dq_oe_q <= 1'b0;
      end

      if (rd_fin_c) begin
        rd_data_q <= io_sram_dq;
      end else if (sil_fin_c) begin
        rd_data_q <= 16'd0;
      end

      // Record pointer update after a completed write
      if (wr_fin_c) begin
        addr_end_q <= EW'(sram_addr_q) + EW'(1);
        if (wr_last_c) begin
          full_q     <= 1'b1;
          state_q    <= ST_IDLE;
          addr_cur_q <= '0;
        end else begin
          addr_cur_q <= sram_addr_q + AW'(1);
        end
      end

      // Playback pointer update after a completed SRAM read
      if (rd_fin_c) begin
        fast_q  <= i_fast;
        speed_q <= i_speed;
        if (play_end_d) begin
          addr_cur_q <= '0;
          rep_q      <= 3'd0;
`ifdef AUDIO_SRAM_PLAY_LOOP_EN
`else
          state_q    <= ST_IDLE;
`endif
        end else begin
          addr_cur_q <= AW'(adv_addr_d);
          rep_q      <= adv_rep_d;
        end
      end

      // Commands: stop > rec > play > pause
      if (i_cmd_stop) begin
        state_q    <= ST_IDLE;
        addr_cur_q <= '0;
        rep_q      <= 3'd0;
      end else if (i_cmd_rec) begin
        if (state_q == ST_IDLE) begin
          state_q    <= ST_REC;
          addr_end_q <= '0;
          full_q     <= 1'b0;
          addr_cur_q <= '0;
        end else if ((state_q == ST_PAUSE) && resume_rec_q) begin
          state_q <= ST_REC;
        end
      end else if (i_cmd_play) begin
        if ((state_q == ST_IDLE) && (addr_end_q != '0)) begin
          state_q    <= ST_PLAY;
          addr_cur_q <= '0;
          rep_q      <= 3'd0;
        end else if ((state_q == ST_PAUSE) && !resume_rec_q) begin
          state_q <= ST_PLAY;
        end
      end else if (i_cmd_pause) begin
        if (state_q == ST_REC) begin
          state_q      <= ST_PAUSE;
          resume_rec_q <= 1'b1;
        end else if (state_q == ST_PLAY) begin
          state_q      <= ST_PAUSE;
          resume_rec_q <= 1'b0;
        end
      end
    end
  end

  // Chip and byte enables are permanently asserted for 16-bit word access
  assign o_sram_ce_n = 1'b0;
  assign o_sram_lb_n = 1'b0;
  assign o_sram_ub_n = 1'b0;

  assign io_sram_dq  = dq_oe_q ? wdata_q : 16'hzzzz;
  assign o_sram_we_n = we_n_q;
  assign o_sram_oe_n = oe_n_q;
  assign o_sram_addr = sram_addr_q;
  assign o_rd_data   = rd_data_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_state     = state_q;
  assign o_addr_cur  = addr_cur_q;
  assign o_addr_end  = addr_end_q;
  assign o_full      = full_q;
  assign o_overrun   = overrun_q;

endmodule
